// File: rtl/edge_det_pkg.sv
// Shared definitions for the multi-channel edge detector.
// Mode encodings and the direction-qualification helper used by every channel.
package edge_det_pkg;

  typedef enum logic [1:0] {
    MODE_OFF  = 2'b00,
    MODE_RISE = 2'b01,
    MODE_FALL = 2'b10,
    MODE_BOTH = 2'b11
  } mode_e;

  // True when an accepted edge in the given direction should raise edge_pulse.
  function automatic logic mode_allows(input logic [1:0] mode_v, input logic is_rise);
    return (mode_v == MODE_BOTH) ||
           (is_rise ? (mode_v == MODE_RISE) : (mode_v == MODE_FALL));
  endfunction

endpackage

// File: rtl/edge_det_chan.sv
// One edge-detector channel: synchroniser, glitch filter, rise/fall detect,
// sticky flag and saturating event counter. All outputs are registered.
module edge_det_chan
  import edge_det_pkg::*;
#(
  parameter int SYNC_STAGES   = 2,
  parameter int FILTER_CYCLES = 4,
  parameter int CNT_WIDTH     = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 signal_in,
  input  logic [1:0]           mode,
  input  logic                 clear,
  output logic                 edge_pulse,
  output logic                 edge_rise,
  output logic                 edge_fall,
  output logic                 event_flag,
  output logic [CNT_WIDTH-1:0] event_count
);

  localparam int                  FCNT_W    = (FILTER_CYCLES > 1) ? $clog2(FILTER_CYCLES) : 1;
  localparam logic [FCNT_W-1:0]    FCNT_LAST = FCNT_W'(FILTER_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX   = '1;

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_filt;
  logic [FCNT_W-1:0]      r_fcnt;
  logic                   r_edge_pulse;
  logic                   r_edge_rise;
  logic                   r_edge_fall;
  logic                   r_event_flag;
  logic [CNT_WIDTH-1:0]   r_event_count;

  logic                   w_synced;
  logic                   w_accept;
  logic                   w_qualify;
  logic                   w_filt_next;
  logic [FCNT_W-1:0]      w_fcnt_next;
  logic                   w_flag_next;
  logic [CNT_WIDTH-1:0]   w_count_next;

  assign w_synced = r_sync[SYNC_STAGES-1];

  // The filter counts consecutive cycles of disagreement; any agreement restarts it.
  always_comb begin
    // NOTE: every signal gets a default before the branches, so no path leaves it unassigned and infers a latch.
    w_filt_next = r_filt;
    w_fcnt_next = '0;
    w_accept    = 1'b0;
    if (w_synced != r_filt) begin
      if (r_fcnt == FCNT_LAST) begin
        w_filt_next = w_synced;
        w_accept    = 1'b1;
      end else begin
        w_fcnt_next = r_fcnt + FCNT_W'(1);
      end
    end
  end

  assign w_qualify = w_accept && mode_allows(mode, w_synced);

  // Clear is applied first so a coinciding qualifying edge still lands as flag=1, count=1.
  always_comb begin
    w_flag_next  = r_event_flag;
    w_count_next = r_event_count;
    if (clear) begin
      w_flag_next  = 1'b0;
      w_count_next = '0;
    end
    if (w_qualify) begin
      w_flag_next = 1'b1;
      if (w_count_next != CNT_MAX) w_count_next = w_count_next + CNT_WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (rst) begin
      r_sync        <= '0;
      r_filt        <= 1'b0;
      r_fcnt        <= '0;
      r_edge_pulse  <= 1'b0;
      r_edge_rise   <= 1'b0;
      r_edge_fall   <= 1'b0;
      r_event_flag  <= 1'b0;
      r_event_count <= '0;
    end else begin
      r_sync        <= {r_sync[SYNC_STAGES-2:0], signal_in};
      r_filt        <= w_filt_next;
      r_fcnt        <= w_fcnt_next;
      r_edge_pulse  <= w_qualify;
      r_edge_rise   <= w_accept && w_synced;
      r_edge_fall   <= w_accept && !w_synced;
      r_event_flag  <= w_flag_next;
      r_event_count <= w_count_next;
    end
  end

  assign edge_pulse  = r_edge_pulse;
  assign edge_rise   = r_edge_rise;
  assign edge_fall   = r_edge_fall;
  assign event_flag  = r_event_flag;
  assign event_count = r_event_count;

endmodule

// File: rtl/multi_edge_detector.sv
// Multi-channel edge detector for asynchronous board inputs.
// Replicates edge_det_chan per channel; this level only slices the buses.
module multi_edge_detector
  import edge_det_pkg::*;
#(
  parameter int CHANNELS      = 4,
  parameter int SYNC_STAGES   = 2,
  parameter int FILTER_CYCLES = 4,
  parameter int CNT_WIDTH     = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [CHANNELS-1:0]           signal_in,
  input  logic [2*CHANNELS-1:0]         mode,
  input  logic [CHANNELS-1:0]           clear,
  output logic [CHANNELS-1:0]           edge_pulse,
  output logic [CHANNELS-1:0]           edge_rise,
  output logic [CHANNELS-1:0]           edge_fall,
  output logic [CHANNELS-1:0]           event_flag,
  output logic [CHANNELS*CNT_WIDTH-1:0] event_count
);

  for (genvar c = 0; c < CHANNELS; c++) begin : g_chan
    edge_det_chan #(
      .SYNC_STAGES  (SYNC_STAGES),
      .FILTER_CYCLES(FILTER_CYCLES),
      .CNT_WIDTH    (CNT_WIDTH)
    ) u_chan (
      .clk        (clk),
      .rst        (rst),
      .signal_in  (signal_in[c]),
      .mode       (mode[2*c +: 2]),
      .clear      (clear[c]),
      .edge_pulse (edge_pulse[c]),
      .edge_rise  (edge_rise[c]),
      .edge_fall  (edge_fall[c]),
      .event_flag (event_flag[c]),
      .event_count(event_count[c*CNT_WIDTH +: CNT_WIDTH])
    );
  end

endmodule

// File: tb/tb_multi_edge_detector.sv
// Self-checking bench for multi_edge_detector: a default-parameter instance checked
// cycle by cycle against a run-length reference model, plus a SYNC_STAGES=3/FILTER_CYCLES=1 instance.
module tb_multi_edge_detector;

  localparam int CH   = 4;
  localparam int SS   = 2;
  localparam int FC   = 4;
  localparam int CW   = 8;
  localparam int OW   = 4*CH + CH*CW;
  localparam int SS_B = 3;
  localparam int FC_B = 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst;
  logic [CH-1:0]    signal_in, clear;
  logic [2*CH-1:0]  mode;
  logic [CH-1:0]    edge_pulse, edge_rise, edge_fall, event_flag;
  logic [CH*CW-1:0] event_count;
  logic [OW-1:0]    dut_outs;

  logic [CH-1:0]    b_signal_in;
  logic [2*CH-1:0]  b_mode;
  logic [CH-1:0]    b_clear;
  logic [CH-1:0]    b_pulse, b_rise, b_fall, b_flag;
  logic [CH*CW-1:0] b_count;

  assign dut_outs = {edge_pulse, edge_rise, edge_fall, event_flag, event_count};

  multi_edge_detector #(.CHANNELS(CH), .SYNC_STAGES(SS), .FILTER_CYCLES(FC), .CNT_WIDTH(CW)) u_dut (
    .clk(clk), .rst(rst), .signal_in(signal_in), .mode(mode), .clear(clear),
    .edge_pulse(edge_pulse), .edge_rise(edge_rise), .edge_fall(edge_fall),
    .event_flag(event_flag), .event_count(event_count)
  );

  multi_edge_detector #(.CHANNELS(CH), .SYNC_STAGES(SS_B), .FILTER_CYCLES(FC_B), .CNT_WIDTH(CW)) u_dut_b (
    .clk(clk), .rst(rst), .signal_in(b_signal_in), .mode(b_mode), .clear(b_clear),
    .edge_pulse(b_pulse), .edge_rise(b_rise), .edge_fall(b_fall),
    .event_flag(b_flag), .event_count(b_count)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: raw samples per edge, the synced value is the sample taken SS edges
  // earlier (zero if a reset intervened), and a level is accepted after FC disagreeing edges in a row.
  logic [CH-1:0] samp [$];
  int            last_rst = -1;
  logic [CH-1:0] m_filt, m_pulse, m_rise, m_fall, m_flag;
  int            m_run   [CH];
  int            m_count [CH];

  task automatic model_step();
    int         n;
    logic       s, acc, qual;
    logic [1:0] md;
    n = samp.size();
    if (rst) begin
      samp.push_back('0);
      last_rst = n;
      m_filt = '0; m_pulse = '0; m_rise = '0; m_fall = '0; m_flag = '0;
      for (int c = 0; c < CH; c++) begin
        m_run[c]   = 0;
        m_count[c] = 0;
      end
      return;
    end
    samp.push_back(signal_in);
    for (int c = 0; c < CH; c++) begin
      s   = (n - SS < 0 || last_rst >= n - SS) ? 1'b0 : samp[n-SS][c];
      acc = 1'b0;
      if (s == m_filt[c]) m_run[c] = 0;
      else begin
        m_run[c]++;
        if (m_run[c] == FC) begin
          m_filt[c] = s;
          m_run[c]  = 0;
          acc       = 1'b1;
        end
      end
      md   = mode[2*c +: 2];
      qual = acc && (md == 2'b11 || (s && md == 2'b01) || (!s && md == 2'b10));
      m_rise[c]  = acc && s;
      m_fall[c]  = acc && !s;
      m_pulse[c] = qual;
      if (clear[c]) begin
        m_flag[c]  = 1'b0;
        m_count[c] = 0;
      end
      if (qual) begin
        m_flag[c] = 1'b1;
        if (m_count[c] < 2**CW - 1) m_count[c]++;
      end
    end
  endtask

  function automatic logic [OW-1:0] model_outs();
    logic [CH*CW-1:0] cnt;
    for (int c = 0; c < CH; c++) cnt[c*CW +: CW] = CW'(m_count[c]);
    return {m_pulse, m_rise, m_fall, m_flag, cnt};
  endfunction

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1; signal_in = 4'b0001; mode = '0; clear = '0;
    repeat (3) tick();
    n_checks++;
    if (dut_outs !== '0) begin
      n_fail++; $display("FAIL reset_outputs got=%h exp=0", dut_outs);
    end
    n_checks++;
    if ({b_pulse, b_rise, b_fall, b_flag, b_count} !== '0) begin
      n_fail++; $display("FAIL reset_outputs_b got=%h exp=0", {b_pulse, b_rise, b_fall, b_flag, b_count});
    end
  endtask

  task automatic test_release_rise();
    int first = -1;
    mode[1:0] = 2'b01;
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      n_checks++;
      if (dut_outs !== model_outs()) begin
        n_fail++; $display("FAIL release_model i=%0d got=%h exp=%h", i, dut_outs, model_outs());
      end
      if (edge_pulse[0] && first < 0) first = i;
    end
    n_checks++;
    if (first != 5) begin n_fail++; $display("FAIL release_latency got=%0d exp=5", first); end
    n_checks++;
    if (event_count[CW-1:0] !== 8'd1) begin
      n_fail++; $display("FAIL release_count got=%0d exp=1", event_count[CW-1:0]);
    end
  endtask

  task automatic test_rise_fall();
    int nr = 0, nf = 0, np = 0;
    mode[3:2] = 2'b11;
    for (int i = 0; i < 22; i++) begin
      signal_in[1] = (i < 10);
      tick();
      n_checks++;
      if (dut_outs !== model_outs()) begin
        n_fail++; $display("FAIL rise_fall_model i=%0d got=%h exp=%h", i, dut_outs, model_outs());
      end
      nr += int'(edge_rise[1]); nf += int'(edge_fall[1]); np += int'(edge_pulse[1]);
    end
    n_checks++;
    if (nr != 1 || nf != 1 || np != 2) begin
      n_fail++; $display("FAIL rise_fall_pulses got=r%0d/f%0d/p%0d exp=r1/f1/p2", nr, nf, np);
    end
    n_checks++;
    if (event_count[CW +: CW] !== 8'd2 || event_flag[1] !== 1'b1) begin
      n_fail++; $display("FAIL rise_fall_count got=%0d/%b exp=2/1", event_count[CW +: CW], event_flag[1]);
    end
  endtask

  task automatic test_glitch();
    int any = 0, nr = 0, np = 0;
    mode[5:4] = 2'b01;
    for (int i = 0; i < 13; i++) begin
      signal_in[2] = (i < 3);
      tick();
      n_checks++;
      if (dut_outs !== model_outs()) begin
        n_fail++; $display("FAIL glitch_model i=%0d got=%h exp=%h", i, dut_outs, model_outs());
      end
      any += int'(edge_rise[2] | edge_fall[2] | edge_pulse[2]);
    end
    n_checks++;
    if (any != 0) begin n_fail++; $display("FAIL glitch_short got=%0d exp=0", any); end
    for (int i = 0; i < 18; i++) begin
      signal_in[2] = (i < 4);
      tick();
      n_checks++;
      if (dut_outs !== model_outs()) begin
        n_fail++; $display("FAIL glitch4_model i=%0d got=%h exp=%h", i, dut_outs, model_outs());
      end
      nr += int'(edge_rise[2]); np += int'(edge_pulse[2]);
    end
    n_checks++;
    if (nr != 1 || np != 1) begin n_fail++; $display("FAIL glitch_accept got=r%0d/p%0d exp=r1/p1", nr, np); end
  endtask

  task automatic test_saturate();
    mode[7:6] = 2'b10;
    for (int p = 0; p < 300; p++) begin
      for (int i = 0; i < 10; i++) begin
        signal_in[3] = (i < 5);
        tick();
        n_checks++;
        if (dut_outs !== model_outs()) begin
          n_fail++; $display("FAIL saturate_model p=%0d got=%h exp=%h", p, dut_outs, model_outs());
        end
      end
    end
    repeat (6) tick();
    n_checks++;
    if (event_count[3*CW +: CW] !== 8'd255 || event_flag[3] !== 1'b1) begin
      n_fail++; $display("FAIL saturate_count got=%0d/%b exp=255/1", event_count[3*CW +: CW], event_flag[3]);
    end
    signal_in[3] = 1'b1;
    repeat (10) tick();
    signal_in[3] = 1'b0;
    repeat (5) tick();
    clear[3] = 1'b1;
    tick();
    clear[3] = 1'b0;
    n_checks++;
    if (edge_pulse[3] !== 1'b1 || event_count[3*CW +: CW] !== 8'd1 || event_flag[3] !== 1'b1) begin
      n_fail++; $display("FAIL clear_with_edge got=p%b/c%0d/f%b exp=p1/c1/f1",
                         edge_pulse[3], event_count[3*CW +: CW], event_flag[3]);
    end
  endtask

  task automatic test_mode_off();
    int nr = 0, nf = 0, np = 0, spur = 0;
    int saved;
    mode[1:0] = 2'b00;
    saved = m_count[0];
    for (int i = 0; i < 16; i++) begin
      signal_in[0] = (i >= 8);
      tick();
      n_checks++;
      if (dut_outs !== model_outs()) begin
        n_fail++; $display("FAIL mode_off_model i=%0d got=%h exp=%h", i, dut_outs, model_outs());
      end
      nr += int'(edge_rise[0]); nf += int'(edge_fall[0]); np += int'(edge_pulse[0]);
    end
    repeat (6) tick();
    n_checks++;
    if (nr != 1 || nf != 1 || np != 0) begin
      n_fail++; $display("FAIL mode_off_pulses got=r%0d/f%0d/p%0d exp=r1/f1/p0", nr, nf, np);
    end
    n_checks++;
    if (int'(event_count[CW-1:0]) != saved) begin
      n_fail++; $display("FAIL mode_off_count got=%0d exp=%0d", event_count[CW-1:0], saved);
    end
    mode = '1;
    for (int i = 0; i < 8; i++) begin
      tick();
      spur += int'(edge_pulse != '0);
    end
    n_checks++;
    if (spur != 0) begin n_fail++; $display("FAIL mode_switch_pulse got=%0d exp=0", spur); end
  endtask

  task automatic test_random();
    int hold [CH];
    for (int c = 0; c < CH; c++) hold[c] = 0;
    for (int i = 0; i < 2000; i++) begin
      for (int c = 0; c < CH; c++) begin
        if (hold[c] == 0) begin
          signal_in[c] = ~signal_in[c];
          hold[c]      = $urandom_range(1, 7);
        end else hold[c]--;
        clear[c] = ($urandom_range(0, 19) == 0);
      end
      if ($urandom_range(0, 49) == 0) mode = 8'($urandom);
      rst = ($urandom_range(0, 499) == 0);
      tick();
      n_checks++;
      if (dut_outs !== model_outs()) begin
        n_fail++; $display("FAIL random_model i=%0d got=%h exp=%h", i, dut_outs, model_outs());
      end
    end
    rst = 1'b0; clear = '0;
  endtask

  task automatic test_reset_mid();
    int seen_all = 0, late = 0;
    mode = '1;
    rst = 1'b1; tick(); rst = 1'b0;
    signal_in = '1;
    for (int i = 0; i < 12; i++) begin
      tick();
      n_checks++;
      if (dut_outs !== model_outs()) begin
        n_fail++; $display("FAIL all_rise_model i=%0d got=%h exp=%h", i, dut_outs, model_outs());
      end
      if (edge_rise === 4'hF && edge_pulse === 4'hF) seen_all++;
    end
    n_checks++;
    if (seen_all != 1) begin n_fail++; $display("FAIL all_rise_same_cycle got=%0d exp=1", seen_all); end
    signal_in = '0;
    repeat (4) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_checks++;
    if (dut_outs !== '0) begin n_fail++; $display("FAIL reset_mid_outputs got=%h exp=0", dut_outs); end
    for (int i = 0; i < 12; i++) begin
      tick();
      late += int'((edge_rise | edge_fall | edge_pulse) != '0);
    end
    n_checks++;
    if (late != 0) begin n_fail++; $display("FAIL reset_mid_late got=%0d exp=0", late); end
  endtask

  task automatic test_latency_b();
    int first = -1, width = 0;
    b_signal_in[0] = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (b_rise[0] && first < 0) first = i;
      width += int'(b_rise[0]);
    end
    n_checks++;
    if (first != 3) begin n_fail++; $display("FAIL latency_b got=%0d exp=3", first); end
    n_checks++;
    if (width != 1 || b_count[CW-1:0] !== 8'd1) begin
      n_fail++; $display("FAIL latency_b_pulse got=w%0d/c%0d exp=w1/c1", width, b_count[CW-1:0]);
    end
  endtask

  initial begin
    rst = 1'b1; signal_in = '0; mode = '0; clear = '0;
    b_signal_in = '0; b_mode = '1; b_clear = '0;
    test_reset();
    test_release_rise();
    test_rise_fall();
    test_glitch();
    test_saturate();
    test_mode_off();
    test_random();
    test_reset_mid();
    test_latency_b();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
